// File: rtl/reg_univ_pkg.sv
// rtl/reg_univ_pkg.sv - shared MODE encodings for the universal register
package reg_univ_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
    localparam logic [MODE_W-1:0] MODE_LOAD = 3'b001;
    localparam logic [MODE_W-1:0] MODE_SHL  = 3'b010;
    localparam logic [MODE_W-1:0] MODE_LSR  = 3'b011;
    localparam logic [MODE_W-1:0] MODE_INC  = 3'b100;
    localparam logic [MODE_W-1:0] MODE_DEC  = 3'b101;
    localparam logic [MODE_W-1:0] MODE_ASR  = 3'b110;
    localparam logic [MODE_W-1:0] MODE_NEG  = 3'b111;

endpackage

// File: rtl/reg_univ_incdec.sv
// rtl/reg_univ_incdec.sv - WIDTH-bit ripple incrementer/decrementer with carry/borrow out
module reg_univ_incdec #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] A,
    input  logic             DEC,
    output logic [WIDTH-1:0] SUM,
    output logic             CARRY
);

    // One chain serves both directions: a carry ripples through ones when
    // incrementing and a borrow ripples through zeros when decrementing.
    always_comb begin
        logic c;
        c   = 1'b1;
        SUM = '0;
        for (int i = 0; i < WIDTH; i++) begin
            SUM[i] = A[i] ^ c;
            c      = c & (A[i] ^ DEC);
        end
        CARRY = c;
    end

endmodule

// File: rtl/reg_univ_pp.sv
// rtl/reg_univ_pp.sv - universal register with pattern reset; REG_UNIV_SAT_EN makes inc/dec saturate
import reg_univ_pkg::*;

module reg_univ_pp #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] PATTERN = '0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              LOAD,
    input  logic [MODE_W-1:0] MODE,
    input  logic [WIDTH-1:0]  D,
    input  logic              SI,
    output logic [WIDTH-1:0]  Q,
    output logic              CO,
    output logic              ZERO
);

    logic [WIDTH-1:0] adder_a;
    logic [WIDTH-1:0] adder_sum;
    logic             adder_carry;
    logic             adder_dec;
    logic [WIDTH-1:0] q_op;
    logic [WIDTH-1:0] q_next;
    logic             co_op;
    logic             co_next;

    // Negate is ~Q + 1, so it shares the incrementer fed with the inverted register.
    assign adder_a   = (MODE == MODE_NEG) ? ~Q : Q;
    assign adder_dec = (MODE == MODE_DEC);

    reg_univ_incdec #(
        .WIDTH(WIDTH)
    ) u_incdec (
        .A     (adder_a),
        .DEC   (adder_dec),
        .SUM   (adder_sum),
        .CARRY (adder_carry)
    );

    always_comb begin
        q_op  = Q;
        co_op = CO;
        case (MODE)
            MODE_HOLD: begin
                q_op  = Q;
                co_op = CO;
            end
            MODE_LOAD: begin
                q_op  = D;
                co_op = 1'b0;
            end
            MODE_SHL: begin
                q_op  = {Q[WIDTH-2:0], SI};
                co_op = Q[WIDTH-1];
            end
            MODE_LSR: begin
                q_op  = {SI, Q[WIDTH-1:1]};
                co_op = Q[0];
            end
            MODE_ASR: begin
                q_op  = {Q[WIDTH-1], Q[WIDTH-1:1]};
                co_op = Q[0];
            end
            default: begin
                q_op  = adder_sum;
                co_op = adder_carry;
            end
        endcase
`ifdef REG_UNIV_SAT_EN
        if (((MODE == MODE_INC) || (MODE == MODE_DEC)) && adder_carry) begin
            q_op = Q;
        end
`endif
    end

    assign q_next  = LOAD ? q_op : Q;
    assign co_next = LOAD ? co_op : CO;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic bit_q;
        always_ff @(posedge CLK) begin
            if (RESET) begin
                bit_q <= PATTERN[i];
            end else begin
                bit_q <= q_next[i];
            end
        end
        assign Q[i] = bit_q;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            CO <= 1'b0;
        end else begin
            CO <= co_next;
        end
    end

    assign ZERO = (Q == '0);

endmodule

// File: tb/tb_reg_univ_pp.sv
// tb/tb_reg_univ_pp.sv - self-checking bench for reg_univ_pp (WIDTH=8, PATTERN=8'hA5)
module tb_reg_univ_pp;

    localparam int          W   = 8;
    localparam logic [7:0]  PAT = 8'hA5;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       load = 1'b0;
    logic [2:0] mode = 3'b000;
    logic [7:0] d = 8'h00;
    logic       si = 1'b0;
    logic [7:0] q;
    logic       co;
    logic       zero;

    int checks = 0;
    int errors = 0;

    int mq = 0;
    int mco = 0;
    bit model_valid = 1'b0;

    always #5 clk = ~clk;

    reg_univ_pp #(
        .WIDTH   (W),
        .PATTERN (PAT)
    ) dut (
        .CLK   (clk),
        .RESET (reset),
        .LOAD  (load),
        .MODE  (mode),
        .D     (d),
        .SI    (si),
        .Q     (q),
        .CO    (co),
        .ZERO  (zero)
    );

    // Spec-level model of one clock edge, in plain integer arithmetic.
    task automatic model_edge();
        int old;
        old = mq;
        if (reset) begin
            mq = PAT;
            mco = 0;
            model_valid = 1'b1;
        end else if (load) begin
            case (mode)
                3'd1: begin mq = d; mco = 0; end
                3'd2: begin mq = ((old * 2) + si) % 256; mco = old / 128; end
                3'd3: begin mq = (old / 2) + (si ? 128 : 0); mco = old % 2; end
                3'd4: begin
`ifdef REG_UNIV_SAT_EN
                    if (old == 255) mco = 1; else begin mq = old + 1; mco = 0; end
`else
                    mq = (old + 1) % 256; mco = (old + 1) / 256;
`endif
                end
                3'd5: begin
`ifdef REG_UNIV_SAT_EN
                    if (old == 0) mco = 1; else begin mq = old - 1; mco = 0; end
`else
                    mq = (old + 255) % 256; mco = (old == 0) ? 1 : 0;
`endif
                end
                3'd6: begin mq = (old / 2) + (old >= 128 ? 128 : 0); mco = old % 2; end
                3'd7: begin mq = (256 - old) % 256; mco = (old == 0) ? 1 : 0; end
                default: ;
            endcase
        end
    endtask

    task automatic op(input logic r, input logic l, input logic [2:0] m,
                      input logic [7:0] dv, input logic s);
        reset = r;
        load  = l;
        mode  = m;
        d     = dv;
        si    = s;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Hand-computed expectation: checks both the DUT and the model against a literal.
    task automatic expect_lit(input string name, input logic [7:0] eq, input logic eco);
        checks++;
        if (q !== eq || co !== eco || zero !== (eq == 8'h00)) begin
            errors++;
            $display("FAIL %s: dut q=%h co=%b zero=%b, required q=%h co=%b zero=%b",
                     name, q, co, zero, eq, eco, (eq == 8'h00));
        end
        checks++;
        if (mq != int'(eq) || mco != int'(eco)) begin
            errors++;
            $display("FAIL %s_model: model q=%0h co=%0d, required q=%h co=%b",
                     name, mq, mco, eq, eco);
        end
    endtask

    always @(negedge clk) begin
        if (model_valid) begin
            checks++;
            if (q !== mq[7:0] || co !== mco[0] || zero !== (mq == 0)) begin
                errors++;
                $display("FAIL cycle_compare @%0t: dut q=%h co=%b zero=%b, required q=%h co=%0d zero=%0d",
                         $time, q, co, zero, mq[7:0], mco, (mq == 0));
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);

        op(1, 1, 3'd4, 8'h00, 1);
        expect_lit("reset", 8'hA5, 1'b0);
        op(0, 0, 3'd1, 8'hFF, 1);
        op(0, 0, 3'd2, 8'h00, 1);
        op(0, 0, 3'd7, 8'h00, 0);
        expect_lit("load0_hold", 8'hA5, 1'b0);

        op(0, 1, 3'd1, 8'h81, 0);
        expect_lit("load_81", 8'h81, 1'b0);
        op(0, 1, 3'd2, 8'h00, 1);
        expect_lit("shl", 8'h03, 1'b1);
        op(0, 1, 3'd0, 8'h55, 0);
        expect_lit("mode_hold", 8'h03, 1'b1);
        op(0, 1, 3'd3, 8'h00, 0);
        expect_lit("lsr", 8'h01, 1'b1);
        op(0, 1, 3'd3, 8'h00, 1);
        expect_lit("lsr_si1", 8'h80, 1'b1);
        op(0, 1, 3'd6, 8'h00, 0);
        expect_lit("asr", 8'hC0, 1'b0);
        op(0, 1, 3'd6, 8'h00, 1);
        op(0, 1, 3'd6, 8'h00, 0);
        expect_lit("asr_twice", 8'hF0, 1'b0);

`ifdef REG_UNIV_SAT_EN
        op(0, 1, 3'd1, 8'hFE, 0);
        op(0, 1, 3'd4, 8'h00, 0);
        expect_lit("inc_to_ff", 8'hFF, 1'b0);
        op(0, 1, 3'd4, 8'h00, 0);
        expect_lit("inc_sat", 8'hFF, 1'b1);
        op(0, 1, 3'd1, 8'h00, 0);
        op(0, 1, 3'd5, 8'h00, 0);
        expect_lit("dec_sat", 8'h00, 1'b1);
`else
        op(0, 1, 3'd1, 8'hFE, 0);
        op(0, 1, 3'd4, 8'h00, 0);
        expect_lit("inc_to_ff", 8'hFF, 1'b0);
        op(0, 1, 3'd4, 8'h00, 0);
        expect_lit("inc_wrap", 8'h00, 1'b1);
        op(0, 1, 3'd5, 8'h00, 0);
        expect_lit("dec_wrap", 8'hFF, 1'b1);
`endif
        op(0, 1, 3'd5, 8'h00, 0);
        expect_lit("dec_plain", (`ifdef REG_UNIV_SAT_EN 8'h00 `else 8'hFE `endif), 1'b`ifdef REG_UNIV_SAT_EN 1 `else 0 `endif);

        op(0, 1, 3'd1, 8'h05, 0);
        expect_lit("load_clears_co", 8'h05, 1'b0);
        op(0, 1, 3'd7, 8'h00, 0);
        expect_lit("neg_05", 8'hFB, 1'b0);
        op(0, 1, 3'd1, 8'h00, 0);
        op(0, 1, 3'd7, 8'h00, 0);
        expect_lit("neg_00", 8'h00, 1'b1);
        op(0, 1, 3'd1, 8'h80, 0);
        op(0, 1, 3'd7, 8'h00, 0);
        expect_lit("neg_80", 8'h80, 1'b0);

        op(0, 1, 3'd1, 8'h10, 0);
        op(0, 1, 3'd4, 8'h00, 0);
        op(0, 1, 3'd4, 8'h00, 0);
        op(0, 1, 3'd4, 8'h00, 0);
        expect_lit("count_13", 8'h13, 1'b0);
        op(1, 1, 3'd4, 8'h00, 0);
        expect_lit("reset_mid_count", 8'hA5, 1'b0);
        op(0, 1, 3'd4, 8'h00, 0);
        op(0, 1, 3'd4, 8'h00, 0);
        expect_lit("count_resume", 8'hA7, 1'b0);

        op(0, 0, 3'd0, 8'h00, 0);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
